// File: rtl/flow_totalizer_bcd.sv
// ============================================================================
// flow_totalizer_bcd
// ----------------------------------------------------------------------------
// Flow-meter totalizer. Rising edges of the asynchronous sensor pulse are
// synchronized into the clk domain and queued in a small pending counter.
// Each queued pulse is added to a packed-BCD volume (mL) by a digit-serial
// BCD adder, one digit per cycle, and the result is committed atomically so
// the display side never sees a half-updated total. Target detection,
// overflow (saturate or wrap) and lost-pulse reporting are sticky flags.
//
// Parameters
//   DIGITS        number of BCD digits in total_bcd / target_bcd (>= 2)
//   ML_PER_PULSE  mL added per accepted pulse, 1..9 (a single BCD digit)
//   SYNC_STAGES   synchronizer depth on pulse_in (>= 2)
//   WRAP          0: saturate at all 9s on overflow, 1: wrap modulo 10^DIGITS
//
// Ports
//   clk             in   system clock, everything on the rising edge
//   rst_n           in   synchronous reset, active low
//   pulse_in        in   raw flow-sensor pulse, asynchronous to clk
//   count_en        in   1: accept new pulse edges, 0: ignore new edges
//   clear           in   synchronous clear of total, flags and queued work
//   target_en       in   enables the target comparison at commit time
//   target_bcd      in   target volume, packed BCD, digit 0 = LSD
//   total_bcd       out  committed total volume, packed BCD
//   update_p        out  one-cycle strobe in the cycle total_bcd changes
//   target_reached  out  sticky: a committed total was >= target while enabled
//   overflow        out  sticky: an add carried out of the top digit
//   pulse_lost      out  sticky: an edge arrived while the queue was full
//   busy            out  FSM not idle, or pulses still queued
// ============================================================================
module flow_totalizer_bcd #(
    parameter int DIGITS       = 4,
    parameter int ML_PER_PULSE = 6,
    parameter int SYNC_STAGES  = 2,
    parameter bit WRAP         = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pulse_in,
    input  logic                count_en,
    input  logic                clear,
    input  logic                target_en,
    input  logic [4*DIGITS-1:0] target_bcd,
    output logic [4*DIGITS-1:0] total_bcd,
    output logic                update_p,
    output logic                target_reached,
    output logic                overflow,
    output logic                pulse_lost,
    output logic                busy
);

    localparam int              TOTAL_W   = 4 * DIGITS;
    localparam int              IDX_W     = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [TOTAL_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [4:0]      ADDEND    = 5'(ML_PER_PULSE);
    localparam logic [3:0]      PEND_MAX  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADD    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_out;
    logic                   pulse_edge;
    logic                   accept;

    // The chain and the edge register only respond to rst_n; clear leaves
    // them running so a pulse already in flight is still seen afterwards.
    // Because both reset to 0, a pulse held high across reset release
    // produces exactly one edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every flop samples the values
        // the other flops held before this edge.
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign pulse_edge = sync_out & ~prev_q;
    assign accept     = pulse_edge & count_en;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t               state_q;
    state_t               state_d;
    logic [3:0]           pending_q;
    logic [3:0]           pending_d;
    logic [IDX_W-1:0]     idx_q;
    logic [TOTAL_W-1:0]   work_q;
    logic                 carry_q;
    logic                 start;
    logic                 add_en;
    logic                 commit;
    logic                 lost_set;

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // through the block leaves it unassigned and no latch is inferred.
        state_d = state_q;
        start   = 1'b0;
        add_en  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q != 4'd0) begin
                    start   = 1'b1;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                add_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Pending pulse queue (a counter: pulses carry no data)
    // ------------------------------------------------------------------
    // An accept and a start in the same cycle cancel out, which is also why
    // a full queue only drops an edge when nothing is leaving it.
    always_comb begin
        pending_d = pending_q;
        lost_set  = 1'b0;
        case ({accept, start})
            2'b10: begin
                if (pending_q == PEND_MAX) begin
                    lost_set = 1'b1;
                end else begin
                    pending_d = pending_q + 4'd1;
                end
            end
            2'b01:   pending_d = pending_q - 4'd1;
            default: pending_d = pending_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit-serial BCD adder
    // ------------------------------------------------------------------
    logic [3:0] cur_digit;
    logic [4:0] digit_sum;
    logic [3:0] new_digit;
    logic       new_carry;

    // The addend only enters at digit 0; higher digits just absorb the
    // ripple carry. Largest sum is 9 + 9 at digit 0, so 5 bits suffice and
    // a single -10 correction always yields a valid digit.
    always_comb begin
        cur_digit = work_q[4*int'(idx_q) +: 4];
        digit_sum = {1'b0, cur_digit} + {4'd0, carry_q}
                  + ((idx_q == '0) ? ADDEND : 5'd0);
        if (digit_sum > 5'd9) begin
            new_digit = 4'(digit_sum - 5'd10);
            new_carry = 1'b1;
        end else begin
            new_digit = digit_sum[3:0];
            new_carry = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else if (clear) begin
            work_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else if (start) begin
            // Work on a private copy; total_bcd only moves at commit.
            work_q  <= total_bcd;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else if (add_en) begin
            work_q[4*int'(idx_q) +: 4] <= new_digit;
            carry_q                    <= new_carry;
            idx_q                      <= idx_q + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Commit, target and sticky flags
    // ------------------------------------------------------------------
    logic [TOTAL_W-1:0] commit_total;
    logic               target_hit;

    always_comb begin
        if (carry_q && !WRAP) begin
            commit_total = ALL_NINES;
        end else begin
            commit_total = work_q;
        end
        // With the most significant digit highest in the word, an unsigned
        // compare is the same as a digit-wise compare starting at the MSD.
        target_hit = target_en && (commit_total >= target_bcd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q      <= 4'd0;
            total_bcd      <= '0;
            update_p       <= 1'b0;
            target_reached <= 1'b0;
            overflow       <= 1'b0;
            pulse_lost     <= 1'b0;
        end else if (clear) begin
            // Clear wins over any edge or commit in the same cycle.
            pending_q      <= 4'd0;
            total_bcd      <= '0;
            update_p       <= 1'b0;
            target_reached <= 1'b0;
            overflow       <= 1'b0;
            pulse_lost     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            update_p  <= commit;
            if (commit) begin
                total_bcd <= commit_total;
                if (carry_q) begin
                    overflow <= 1'b1;
                end
                if (target_hit) begin
                    target_reached <= 1'b1;
                end
            end
            if (lost_set) begin
                pulse_lost <= 1'b1;
            end
        end
    end

    assign busy = (state_q != S_IDLE) || (pending_q != 4'd0);

endmodule

// File: tb/tb_flow_totalizer_bcd.sv
module tb_flow_totalizer_bcd;

    localparam int DIGITS = 4;
    localparam int ML     = 6;
    localparam int SYNC   = 2;
    localparam int MODV   = 10 ** DIGITS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pulse_in = 1'b0;
    logic        count_en = 1'b1;
    logic        clear = 1'b0;
    logic        target_en = 1'b0;
    logic [15:0] target_bcd = 16'h0000;

    logic [15:0] total_s, total_w;
    logic        update_s, update_w, tr_s, tr_w, ov_s, ov_w, lost_s, lost_w, busy_s, busy_w;

    always #5 clk = ~clk;

    flow_totalizer_bcd #(.DIGITS(DIGITS), .ML_PER_PULSE(ML), .SYNC_STAGES(SYNC), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .count_en(count_en), .clear(clear),
        .target_en(target_en), .target_bcd(target_bcd), .total_bcd(total_s), .update_p(update_s),
        .target_reached(tr_s), .overflow(ov_s), .pulse_lost(lost_s), .busy(busy_s));

    flow_totalizer_bcd #(.DIGITS(DIGITS), .ML_PER_PULSE(ML), .SYNC_STAGES(SYNC), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .count_en(count_en), .clear(clear),
        .target_en(target_en), .target_bcd(target_bcd), .total_bcd(total_w), .update_p(update_w),
        .target_reached(tr_w), .overflow(ov_w), .pulse_lost(lost_w), .busy(busy_w));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int bcd2int(input logic [15:0] b);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a counter queue feeding a server that needs
    // DIGITS+2 cycles per pulse; totals kept as plain integers.
    // Index 0 = saturating instance, 1 = wrapping instance.
    // ------------------------------------------------------------------
    int  cyc = 0;
    bit  arr_at [int];
    int  m_q = 0;
    bit  m_act = 0;
    int  m_commit_at = 0;
    int  m_tot [2] = '{0, 0};
    bit  m_ov [2] = '{0, 0};
    bit  m_tr [2] = '{0, 0};
    bit  m_lost = 0;
    bit  m_upd = 0;
    bit  chk_en = 0;

    task automatic model_zero();
        m_q = 0; m_act = 0; m_lost = 0; m_upd = 0;
        for (int i = 0; i < 2; i++) begin m_tot[i] = 0; m_ov[i] = 0; m_tr[i] = 0; end
    endtask

    task automatic model_step();
        bit arrival, start;
        int sum;
        cyc++;
        arrival = arr_at.exists(cyc);
        if (arrival) arr_at.delete(cyc);
        m_upd = 0;
        if (!rst_n || clear) begin
            model_zero();
        end else begin
            start = !m_act && (m_q > 0);
            if (m_act && cyc == m_commit_at) begin
                for (int i = 0; i < 2; i++) begin
                    sum = m_tot[i] + ML;
                    if (sum >= MODV) begin
                        m_ov[i]  = 1;
                        m_tot[i] = (i == 0) ? MODV - 1 : sum - MODV;
                    end else begin
                        m_tot[i] = sum;
                    end
                    if (target_en && m_tot[i] >= bcd2int(target_bcd)) m_tr[i] = 1;
                end
                m_upd = 1;
                m_act = 0;
            end
            if (start) begin
                m_act = 1;
                m_commit_at = cyc + DIGITS + 1;
            end
            if (arrival && count_en) begin
                if (m_q == 15 && !start) m_lost = 1;
                else m_q++;
            end
            if (start) m_q--;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle", {22'd0, total_s, total_w, update_s, update_w, ov_s, ov_w, tr_s, tr_w,
                            lost_s, lost_w, busy_s, busy_w},
                  {22'd0, int2bcd(m_tot[0]), int2bcd(m_tot[1]), m_upd, m_upd, m_ov[0], m_ov[1],
                   m_tr[0], m_tr[1], m_lost, m_lost, (m_q > 0) || m_act, (m_q > 0) || m_act});
        end
    end

    // ------------------------------------------------------------------
    // Drivers (all start and end on a falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        pulse_in = 1'b1;
        arr_at[cyc + 1 + SYNC] = 1'b1;
        tick(hi);
        pulse_in = 1'b0;
        tick(lo);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy_s || busy_w) && k < 400) begin
            tick(1);
            k++;
        end
        check(name, {busy_s, busy_w}, 2'b00);
        tick(2);
    endtask

    typedef struct {
        bit          clr;
        int          n;
        int          period;
        int          hi;
        bit          cen;
        bit          ten;
        logic [15:0] tgt;
        logic [15:0] exp_s;
        logic [15:0] exp_w;
        bit          ov_s;
        bit          ov_w;
        bit          tr;
        bit          lost;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 1,    10, 5, 1'b1, 1'b0, 16'h0000, 16'h0006, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 17,   10, 5, 1'b1, 1'b0, 16'h0000, 16'h0102, 16'h0102, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 166,  8,  4, 1'b1, 1'b0, 16'h0000, 16'h0996, 16'h0996, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1,    10, 5, 1'b1, 1'b0, 16'h0000, 16'h1002, 16'h1002, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1667, 6,  3, 1'b1, 1'b0, 16'h0000, 16'h9999, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1,    10, 5, 1'b1, 1'b0, 16'h0000, 16'h9999, 16'h0008, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4,    10, 5, 1'b1, 1'b1, 16'h0030, 16'h0024, 16'h0024, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1,    10, 5, 1'b1, 1'b1, 16'h0030, 16'h0030, 16'h0030, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1,    10, 5, 1'b1, 1'b0, 16'h0030, 16'h0036, 16'h0036, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 60,   4,  2, 1'b1, 1'b0, 16'h0000, 16'h0330, 16'h0330, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 5,    6,  3, 1'b0, 1'b0, 16'h0000, 16'h0330, 16'h0330, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 2,    8,  4, 1'b1, 1'b0, 16'h0000, 16'h0342, 16'h0342, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset
        tick(3);
        chk_en = 1'b1;
        check("reset_outputs", {total_s, update_s, tr_s, ov_s, lost_s, busy_s}, '0);
        rst_n = 1'b1;
        tick(2);

        // Table-driven scenarios
        for (int v = 0; v < 12; v++) begin
            count_en   = tbl[v].cen;
            target_en  = tbl[v].ten;
            target_bcd = tbl[v].tgt;
            if (tbl[v].clr) begin
                do_clear();
                tick(1);
            end
            for (int p = 0; p < tbl[v].n; p++) pulse(tbl[v].hi, tbl[v].period - tbl[v].hi);
            wait_idle($sformatf("tbl%0d_idle", v));
            check($sformatf("tbl%0d_total_sat", v), total_s, tbl[v].exp_s);
            check($sformatf("tbl%0d_total_wrap", v), total_w, tbl[v].exp_w);
            check($sformatf("tbl%0d_flags", v), {ov_s, ov_w, tr_s, tr_w, lost_s, lost_w},
                  {tbl[v].ov_s, tbl[v].ov_w, tbl[v].tr, tbl[v].tr, tbl[v].lost, tbl[v].lost});
        end
        count_en  = 1'b1;
        target_en = 1'b0;

        // Latency: busy rises when the edge is queued; update_p 6 cycles later, 1 cycle wide
        begin
            int u;
            do_clear();
            tick(1);
            pulse_in = 1'b1;
            arr_at[cyc + 1 + SYNC] = 1'b1;
            tick(3);
            pulse_in = 1'b0;
            check("busy_after_edge", busy_s, 1'b1);
            u = 0;
            while (!update_s && u < 20) begin
                tick(1);
                u++;
            end
            check("commit_latency", u, 6);
            check("commit_total", total_s, 16'h0006);
            tick(1);
            check("update_width", update_s, 1'b0);
            wait_idle("latency_idle");
        end

        // Clear in the middle of an add with pulses still queued
        begin
            bit seen;
            do_clear();
            tick(1);
            for (int p = 0; p < 5; p++) pulse(2, 2);
            tick(2);
            check("busy_before_clear", {busy_s, total_s != 16'h0}, 2'b11);
            do_clear();
            check("after_clear", {total_s, update_s, tr_s, ov_s, lost_s, busy_s}, '0);
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick(1);
                seen = seen | update_s;
            end
            check("no_update_after_clear", {seen, total_s}, '0);
        end

        // Reset in the middle of an add: no partial commit
        begin
            bit seen;
            pulse(2, 2);
            wait_idle("pre_reset_idle");
            check("pre_reset_total", total_s, 16'h0006);
            pulse(2, 2);
            tick(1);
            rst_n = 1'b0;
            tick(1);
            check("reset_mid_add", {total_s, update_s, busy_s}, '0);
            rst_n = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick(1);
                seen = seen | update_s;
            end
            check("no_update_after_reset", {seen, total_s}, '0);
        end

        // Pulse held high across reset release counts once
        rst_n = 1'b0;
        pulse_in = 1'b1;
        tick(3);
        rst_n = 1'b1;
        arr_at[cyc + 1 + SYNC] = 1'b1;
        tick(4);
        pulse_in = 1'b0;
        tick(2);
        wait_idle("held_pulse_idle");
        check("pulse_across_reset", total_s, 16'h0006);

        // Randomized traffic checked cycle by cycle against the model
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_clear();
            end else begin
                int n;
                count_en   = ($urandom_range(0, 4) != 0);
                target_en  = $urandom_range(0, 1) == 1;
                target_bcd = int2bcd(int'($urandom_range(0, 400)));
                n = int'($urandom_range(1, 8));
                for (int p = 0; p < n; p++) begin
                    int per, hi;
                    per = int'($urandom_range(4, 10));
                    hi  = int'($urandom_range(2, per - 2));
                    pulse(hi, per - hi);
                    if ($urandom_range(0, 15) == 0) do_clear();
                end
            end
            tick(int'($urandom_range(0, 8)));
        end
        wait_idle("random_idle");
        check("random_final_sat", total_s, int2bcd(m_tot[0]));
        check("random_final_wrap", total_w, int2bcd(m_tot[1]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
